tt_sweep_ctrl: RTL and testbench

- Sequencer that drives a combinational block-under-test through every input vector, 0 to 2**N_IN-1.
- Waits a programmable settle time per vector, captures the outputs, and compares them against a packed expected truth table.
- Reports pass/fail, mismatch count and the first failing vector.
- Used on-board and in benches as the self-checking replacement for hand-written stimulus lists on the small combinational lab circuits (3-in/2-out).

---
 rtl/tt_sweep_ctrl.sv | 109 ++++++++++
 tb/tb_tt_sweep_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive input sweeper for small combinational circuits: steps every input vector,
// waits a settle time, captures the outputs and scores them against a packed truth table.
module tt_sweep_ctrl #(
    parameter int N_IN          = 3,
    parameter int N_OUT         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [(2**N_IN)*N_OUT-1:0]   exp_table,
    output logic [N_IN-1:0]              dut_in,
    input  logic [N_OUT-1:0]             dut_out,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [N_IN:0]                mismatch_cnt,
    output logic [N_IN-1:0]              first_fail,
    output logic [(2**N_IN)*N_OUT-1:0]   captured
);

    localparam int               V        = 2**N_IN;
    localparam logic [7:0]       CNT_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [N_IN:0]    MM_MAX   = (N_IN+1)'(V);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q;
    logic [N_IN-1:0]         vec_q;
    logic [7:0]              cnt_q;
    logic [N_IN:0]           mm_q;
    logic [N_IN-1:0]         ff_q;
    logic [V*N_OUT-1:0]      cap_q;
    logic [N_OUT-1:0]        exp_d;

    assign exp_d = exp_table[int'(vec_q)*N_OUT +: N_OUT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            mm_q    <= '0;
            ff_q    <= '0;
            cap_q   <= '0;
        end else if (abort) begin
            // Partial results stay visible for post-mortem after an abort.
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vec_q   <= '0;
                        cnt_q   <= '0;
                        mm_q    <= '0;
                        ff_q    <= '0;
                        cap_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                CAPTURE: begin
                    cap_q[int'(vec_q)*N_OUT +: N_OUT] <= dut_out;
                    // Written as match/else so an unknown compare lands on the mismatch side.
                    if (dut_out == exp_d) begin
                        mm_q <= mm_q;
                    end else begin
                        if (mm_q == '0) begin
                            ff_q <= vec_q;
                        end
                        if (mm_q != MM_MAX) begin
                            mm_q <= mm_q + 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dut_in       = vec_q;
    assign busy         = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done         = (state_q == DONE);
    assign pass         = done && (mm_q == '0);
    assign mismatch_cnt = mm_q;
    assign first_fail   = ff_q;
    assign captured     = cap_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: two instances (settle 2 and settle 1) sweep a
// bench-owned lookup-table circuit; a negedge monitor scores each completed sweep.
module tb_tt_sweep_ctrl;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int V     = 8;
    localparam int S0    = 2;
    localparam int S1    = 1;

    typedef struct {
        logic [15:0] cap;
        int          mm;
        int          ff;
        bit          pass;
        int          done_cyc;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] exp_table, but_tab;
    logic [2:0]  din0, din1, ff0, ff1;
    logic [1:0]  dout0, dout1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0]  mm0, mm1;
    logic [15:0] cap0, cap1;

    rec_t q0[$];
    rec_t q1[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ts0, ts1;
    bit   trk0 = 0, trk1 = 0;
    logic d0_prev = 1'b0, d1_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dout0 = but_tab[int'(din0)*2 +: 2];
    assign dout1 = but_tab[int'(din1)*2 +: 2];

    tt_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(S0)) u0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .exp_table(exp_table),
        .dut_in(din0), .dut_out(dout0), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_cnt(mm0), .first_fail(ff0), .captured(cap0)
    );

    tt_sweep_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE_CYCLES(S1)) u1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .exp_table(exp_table),
        .dut_in(din1), .dut_out(dout1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_cnt(mm1), .first_fail(ff1), .captured(cap1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Full adder truth table {x,y} per input vector {a,b,c}, optionally with y stuck low.
    function automatic logic [15:0] fa_tab(input bit stuck_y);
        logic [15:0] t;
        logic [2:0]  abc;
        logic        x, y;
        t = '0;
        for (int v = 0; v < V; v++) begin
            abc = 3'(v);
            x = abc[2] ^ abc[1] ^ abc[0];
            y = (abc[2] & abc[1]) | (abc[2] & abc[0]) | (abc[1] & abc[0]);
            if (stuck_y) y = 1'b0;
            t[2*v +: 2] = {x, y};
        end
        return t;
    endfunction

    // Result of sweeping the first n vectors of circuit `but` against table `ex`.
    function automatic rec_t model(input logic [15:0] but, input logic [15:0] ex, input int n);
        rec_t r;
        r.cap = '0;
        r.mm  = 0;
        r.ff  = 0;
        for (int v = 0; v < n; v++) begin
            r.cap[2*v +: 2] = but[2*v +: 2];
            if (but[2*v +: 2] !== ex[2*v +: 2]) begin
                if (r.mm == 0) r.ff = v;
                r.mm++;
            end
        end
        r.pass     = (r.mm == 0) && (n == V);
        r.done_cyc = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        rec_t r;
        d0_prev <= done0;
        d1_prev <= done1;
        if (trk0 && busy0) chk("din0_step", 32'(din0), 32'((cyc - ts0) / (S0 + 1)));
        if (trk1 && busy1) chk("din1_step", 32'(din1), 32'((cyc - ts1) / (S1 + 1)));
        if (done0 && !d0_prev) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL u0_unexpected_done: got done=1 expected no sweep result (t=%0t)", $time);
            end else begin
                r = q0.pop_front();
                chk("u0_done_cycle", 32'(cyc), 32'(r.done_cyc));
                chk("u0_pass", 32'(pass0), 32'(r.pass));
                chk("u0_mismatch_cnt", 32'(mm0), 32'(r.mm));
                chk("u0_first_fail", 32'(ff0), 32'(r.ff));
                chk("u0_captured", 32'(cap0), 32'(r.cap));
            end
        end
        if (done1 && !d1_prev) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL u1_unexpected_done: got done=1 expected no sweep result (t=%0t)", $time);
            end else begin
                r = q1.pop_front();
                chk("u1_done_cycle", 32'(cyc), 32'(r.done_cyc));
                chk("u1_pass", 32'(pass1), 32'(r.pass));
                chk("u1_mismatch_cnt", 32'(mm1), 32'(r.mm));
                chk("u1_first_fail", 32'(ff1), 32'(r.ff));
                chk("u1_captured", 32'(cap1), 32'(r.cap));
            end
        end
    end

    // Pulse start for one cycle; both instances are idle or done here, so both accept it.
    task automatic launch();
        rec_t r;
        start = 1'b1;
        r = model(but_tab, exp_table, V);
        r.done_cyc = cyc + 1 + V * (S0 + 1);
        q0.push_back(r);
        r.done_cyc = cyc + 1 + V * (S1 + 1);
        q1.push_back(r);
        ts0 = cyc + 1;
        ts1 = cyc + 1;
        trk0 = 1;
        trk1 = 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_both();
        for (int i = 0; i < 200; i++) begin
            if (done0 && done1) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL wait_done: got done0=%0b done1=%0b expected both high within 200 cycles", done0, done1);
    endtask

    task automatic drop_pending();
        if (q0.size() > 0) void'(q0.pop_back());
        if (q1.size() > 0) void'(q1.pop_back());
        trk0 = 0;
        trk1 = 0;
    endtask

    initial begin
        rec_t p;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        but_tab   = fa_tab(0);
        exp_table = 16'hD668;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_mm", 32'(mm0), 0);
        chk("rst_captured", 32'(cap0), 0);
        chk("rst_dut_in", 32'(din0), 0);
        reset = 1'b0;
        @(negedge clk);

        // Correct full adder, with a start pulse injected mid-sweep that must be ignored.
        launch();
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_both();

        // Restart straight from DONE: done must drop on the next cycle.
        launch();
        chk("restart_done0_low", 32'(done0), 0);
        chk("restart_done1_low", 32'(done1), 0);
        wait_both();

        // y stuck-at-0 against the correct table.
        but_tab = fa_tab(1);
        launch();
        wait_both();

        // Abort while u0 is settling vector 4.
        but_tab = fa_tab(1);
        launch();
        repeat (12) @(negedge clk);
        abort = 1'b1;
        drop_pending();
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy0", 32'(busy0), 0);
        chk("abort_done0", 32'(done0), 0);
        chk("abort_pass0", 32'(pass0), 0);
        chk("abort_din0_hold", 32'(din0), 4);
        p = model(but_tab, exp_table, 12 / (S0 + 1));
        chk("abort_cap0", 32'(cap0), 32'(p.cap));
        chk("abort_mm0", 32'(mm0), 32'(p.mm));
        p = model(but_tab, exp_table, 12 / (S1 + 1));
        chk("abort_cap1", 32'(cap1), 32'(p.cap));
        chk("abort_mm1", 32'(mm1), 32'(p.mm));

        // start and abort together from IDLE: nothing happens.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("start_abort_busy", 32'(busy0 | busy1), 0);
            @(negedge clk);
        end
        but_tab = fa_tab(0);
        launch();
        wait_both();

        // Asynchronous reset in the middle of u0's vector 2.
        launch();
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        drop_pending();
        chk("arst_busy", 32'(busy0 | busy1), 0);
        chk("arst_done", 32'(done0 | done1), 0);
        chk("arst_mm", 32'(mm0 | mm1), 0);
        chk("arst_cap", 32'(cap0 | cap1), 0);
        chk("arst_din", 32'(din0 | din1), 0);
        chk("arst_ff", 32'(ff0 | ff1), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch();
        wait_both();

        // Random circuits against random or matching tables.
        for (int k = 0; k < 8; k++) begin
            but_tab = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       exp_table = but_tab;
                1:       exp_table = but_tab ^ (16'h1 << $urandom_range(0, 15));
                default: exp_table = 16'($urandom);
            endcase
            launch();
            wait_both();
        end

        repeat (3) @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_results: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
